// File: rtl/debounce_pkg.sv
// Shared debounce constants and width helper.
// Also reused by the UART baud-tick logic.
package debounce_pkg;

    localparam int DEF_TICK_DIV     = 100000;
    localparam int DEF_STABLE_TICKS = 20;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int cnt_width(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_if.sv
// Switch-side and event-side signals of the debounce bank.
// The bank drives the slave side; the SoC/bench the master side.
interface debounce_if #(
    parameter int N = 4
);

    logic [N-1:0] sw_in;
    logic [N-1:0] db_out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic         any_event;

    modport master (
        output sw_in,
        input  db_out,
        input  rise,
        input  fall,
        input  any_event
    );

    modport slave (
        input  sw_in,
        output db_out,
        output rise,
        output fall,
        output any_event
    );

endinterface

// File: rtl/debounce_tick_gen.sv
// Shared sample-tick divider: one-cycle tick every TICK_DIV clocks.
// First tick lands TICK_DIV cycles after reset release.
module debounce_tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = cnt_width(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// N-channel switch debouncer sharing one sample tick.
// Each channel: synchroniser, stability counter, level and edge pulses.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int           N            = 4,
    parameter int           TICK_DIV     = DEF_TICK_DIV,
    parameter int           STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int           SYNC_STAGES  = 2,
    parameter logic [N-1:0] RST_VAL      = '0
) (
    input logic       clk,
    input logic       rst,
    debounce_if.slave bus
);

    localparam int CW = cnt_width(STABLE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          tick;
    logic [N-1:0]  s;
    logic [N-1:0]  db;
    logic [N-1:0]  rise_q;
    logic [N-1:0]  fall_q;
    logic [CW-1:0] cnt [N];
    logic          any_q;

    debounce_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic [CW-1:0]          cnt_q;
        logic                   db_q;
        logic                   rise_r;
        logic                   fall_r;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync <= {SYNC_STAGES{RST_VAL[i]}};
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], bus.sw_in[i]};
            end
        end

        assign s[i] = sync[SYNC_STAGES-1];

        // Any agreeing sample restarts the window, even between ticks.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                db_q   <= RST_VAL[i];
                cnt_q  <= '0;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                rise_r <= 1'b0;
                fall_r <= 1'b0;
                if (s[i] == db_q) begin
                    cnt_q <= '0;
                end else if (tick) begin
                    if (cnt[i] == LAST) begin
                        db_q   <= s[i];
                        cnt_q  <= '0;
                        rise_r <= s[i];
                        fall_r <= ~s[i];
                    end else begin
                        cnt_q <= cnt[i] + CW'(1);
                    end
                end
            end
        end

        assign cnt[i]    = cnt_q;
        assign db[i]     = db_q;
        assign rise_q[i] = rise_r;
        assign fall_q[i] = fall_r;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |(rise_q | fall_q);
        end
    end

    assign bus.db_out    = db;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.any_event = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (TICK_DIV=4, STABLE_TICKS=3, N=4).
module tb_debounce_bank;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    debounce_if #(.N(4)) bus ();

    debounce_bank #(
        .N           (4),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .SYNC_STAGES (2),
        .RST_VAL     (4'b0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b0;
        bus.sw_in = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            bus.sw_in = ~bus.sw_in;
            step();
            checks++;
            if (bus.db_out !== 4'b0000 || bus.rise !== 4'b0000
                || bus.fall !== 4'b0000 || bus.any_event !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold db=%b rise=%b fall=%b any=%b want 0",
                         bus.db_out, bus.rise, bus.fall, bus.any_event);
            end
        end
        bus.sw_in = 4'b0000;
        step();
        rst = 1'b1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (bus.rise !== 4'b0000 || bus.fall !== 4'b0000
                || bus.any_event !== 1'b0 || bus.db_out !== 4'b0000) begin
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_release bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_press();
        int n;
        bus.sw_in[0] = 1'b1;
        n = 0;
        while (n < 20 && bus.db_out[0] !== 1'b1) begin
            step();
            n++;
        end
        checks++;
        if (n < 11 || n > 14 || bus.db_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL press_latency got=%0d want 11..14", n);
        end
        checks++;
        if (bus.rise !== 4'b0001 || bus.fall !== 4'b0000) begin
            failures++;
            $display("FAIL press_pulse rise=%b fall=%b want 0001/0000",
                     bus.rise, bus.fall);
        end
        step();
        checks++;
        if (bus.rise !== 4'b0000 || bus.any_event !== 1'b1) begin
            failures++;
            $display("FAIL press_any rise=%b any=%b want 0000/1",
                     bus.rise, bus.any_event);
        end
        step();
        checks++;
        if (bus.any_event !== 1'b0) begin
            failures++;
            $display("FAIL press_any_clear any=%b want 0", bus.any_event);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        bus.sw_in[1] = 1'b1;
        for (int k = 0; k < 26; k++) begin
            if (k == 6) bus.sw_in[1] = 1'b0;
            step();
            if (bus.db_out[1] !== 1'b0 || bus.rise[1] !== 1'b0
                || bus.fall[1] !== 1'b0) begin
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL glitch_pass bad_cycles=%0d want 0", bad);
        end
        checks++;
        if (dut.cnt[1] !== 2'd0) begin
            failures++;
            $display("FAIL glitch_cnt got=%0d want 0", dut.cnt[1]);
        end
    endtask

    task automatic test_bounce();
        int bad;
        int rises;
        int first;
        bad = 0;
        for (int p = 0; p < 10; p++) begin
            bus.sw_in[2] = (p % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                step();
                if (bus.rise[2] !== 1'b0 || bus.db_out[2] !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bounce_pass bad_cycles=%0d want 0", bad);
        end
        bus.sw_in[2] = 1'b1;
        rises = 0;
        first = 0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (bus.rise[2] === 1'b1) begin
                rises++;
                if (first == 0) first = n;
            end
        end
        checks++;
        if (rises !== 1) begin
            failures++;
            $display("FAIL bounce_rises got=%0d want 1", rises);
        end
        checks++;
        if (first < 11 || first > 14 || bus.db_out[2] !== 1'b1) begin
            failures++;
            $display("FAIL bounce_latency got=%0d db=%b want 11..14/1",
                     first, bus.db_out[2]);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        bus.sw_in = 4'b0000;
        repeat (20) step();
        checks++;
        if (bus.db_out !== 4'b0000) begin
            failures++;
            $display("FAIL simul_clear db=%b want 0000", bus.db_out);
        end
        bus.sw_in = 4'b1111;
        n = 0;
        while (n < 20 && bus.rise === 4'b0000) begin
            step();
            n++;
        end
        checks++;
        if (bus.rise !== 4'b1111 || bus.db_out !== 4'b1111) begin
            failures++;
            $display("FAIL simul_rise rise=%b db=%b want 1111/1111",
                     bus.rise, bus.db_out);
        end
        step();
        checks++;
        if (bus.rise !== 4'b0000 || bus.any_event !== 1'b1) begin
            failures++;
            $display("FAIL simul_rise_end rise=%b any=%b want 0000/1",
                     bus.rise, bus.any_event);
        end
        bus.sw_in = 4'b0101;
        n = 0;
        while (n < 20 && bus.fall === 4'b0000) begin
            step();
            n++;
        end
        checks++;
        if (bus.fall !== 4'b1010 || bus.rise !== 4'b0000
            || bus.db_out !== 4'b0101) begin
            failures++;
            $display("FAIL simul_fall fall=%b rise=%b db=%b want 1010/0000/0101",
                     bus.fall, bus.rise, bus.db_out);
        end
        step();
        checks++;
        if (bus.fall !== 4'b0000) begin
            failures++;
            $display("FAIL simul_fall_end fall=%b want 0000", bus.fall);
        end
    endtask

    task automatic test_reset_mid_filter();
        int n;
        bus.sw_in = 4'b0000;
        repeat (20) step();
        bus.sw_in[0] = 1'b1;
        n = 0;
        while (n < 20 && dut.cnt[0] !== 2'd2) begin
            step();
            n++;
        end
        checks++;
        if (dut.cnt[0] !== 2'd2 || bus.db_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrst_setup cnt=%0d db=%b want 2/0",
                     dut.cnt[0], bus.db_out[0]);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.db_out !== 4'b0000 || dut.cnt[0] !== 2'd0
            || bus.rise !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_state db=%b cnt=%0d rise=%b want 0000/0/0000",
                     bus.db_out, dut.cnt[0], bus.rise);
        end
        step();
        rst = 1'b1;
        n = 0;
        while (n < 20 && bus.db_out[0] !== 1'b1) begin
            step();
            n++;
        end
        checks++;
        if (n !== 12 || bus.rise[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_window got=%0d rise=%b want 12/1",
                     n, bus.rise[0]);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        bus.sw_in = 4'b0000;
        test_reset();
        test_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_filter();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
